ex_stage: RTL

//  Execute stage: consumes ID/EX register outputs, resolves RAW hazards by forwarding

---
 rtl/ex_pkg.sv | 20 ++
 rtl/ex_mul_iter.sv | 64 ++++++
 rtl/ex_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings, the multiplier
// FSM state type and default datapath widths.
package ex_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_W_DEF  = 3;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MUL = 2'b11
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock for DATA_W
// clocks. The low DATA_W bits of the product appear on result during the last step.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              last,
  output logic [DATA_W-1:0] result
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;

  // NOTE: every output of a combinational block is given a default first so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = (state_q == BUSY);
    last    = busy && (cnt_q == LAST_CNT);
    result  = mcand_q[0] ? acc_q + mplier_q : acc_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the multiplier working registers are reset explicitly so an aborted
  // multiply leaves nothing behind that a later start could observe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        mcand_q  <= a;
        mplier_q <= b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == BUSY) begin
        if (mcand_q[0]) acc_q <= acc_q + mplier_q;
        mcand_q  <= mcand_q >> 1;
        mplier_q <= mplier_q << 1;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwards from its own EX/WB register, runs the ALU (with an
// iterative multiplier that stalls upstream) and registers the result into EX/WB.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_ID_EX,
  input  logic [1:0]        ALUop_ID_EX,
  input  logic [DATA_W-1:0] Data1_ID_EX,
  input  logic [DATA_W-1:0] Data2_ID_EX,
  input  logic [REG_W-1:0]  Rd_ID_EX,
  input  logic [REG_W-1:0]  Rs1_ID_EX,
  input  logic [REG_W-1:0]  Rs2_ID_EX,
  output logic              RegWrite_EX_WB,
  output logic [REG_W-1:0]  Rd_EX_WB,
  output logic [DATA_W-1:0] Result_EX_WB,
  output logic              stall_EX
);

  localparam bit ZR = (ZERO_REG != 0);

  alu_op_e           op;
  logic              fwd_a, fwd_b;
  logic [DATA_W-1:0] op_a, op_b, alu_y;
  logic              mul_start, mul_busy, mul_last;
  logic [DATA_W-1:0] mul_result;
  logic [REG_W-1:0]  rd_mul_q;
  logic              wb_we, mul_we;

  assign op = alu_op_e'(ALUop_ID_EX);

  always_comb begin
    fwd_a = RegWrite_EX_WB && (Rd_EX_WB == Rs1_ID_EX) && !(ZR && Rs1_ID_EX == '0);
    fwd_b = RegWrite_EX_WB && (Rd_EX_WB == Rs2_ID_EX) && !(ZR && Rs2_ID_EX == '0);
    op_a  = fwd_a ? Result_EX_WB : Data1_ID_EX;
    op_b  = fwd_b ? Result_EX_WB : Data2_ID_EX;
    alu_y = '0;
    case (op)
      ALU_ADD: alu_y = op_a + op_b;
      ALU_SUB: alu_y = op_a - op_b;
      ALU_AND: alu_y = op_a & op_b;
      default: alu_y = '0;  // MUL goes through the iterative unit
    endcase
  end

  // A MUL only starts when it really writes; a MUL bubble takes the 1-cycle path.
  assign mul_start = !mul_busy && RegWrite_ID_EX && (op == ALU_MUL);
  assign stall_EX  = mul_start || (mul_busy && !mul_last);
  assign wb_we     = RegWrite_ID_EX && !(ZR && Rd_ID_EX == '0);
  assign mul_we    = !(ZR && rd_mul_q == '0);

  ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (op_a),
    .b      (op_b),
    .busy   (mul_busy),
    .last   (mul_last),
    .result (mul_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWrite_EX_WB <= 1'b0;
      Rd_EX_WB       <= '0;
      Result_EX_WB   <= '0;
      rd_mul_q       <= '0;
    end else if (mul_busy) begin
      RegWrite_EX_WB <= mul_last && mul_we;
      if (mul_last) begin
        Rd_EX_WB     <= rd_mul_q;
        Result_EX_WB <= mul_result;
      end
    end else if (mul_start) begin
      RegWrite_EX_WB <= 1'b0;
      rd_mul_q       <= Rd_ID_EX;
    end else begin
      RegWrite_EX_WB <= wb_we;
      Rd_EX_WB       <= Rd_ID_EX;
      Result_EX_WB   <= alu_y;
    end
  end

endmodule
